// File: rtl/branch_cmp_seq.sv
// -----------------------------------------------------------------------------
// branch_cmp_seq
//   Multi-cycle branch comparator. Operands are compared SLICE bits per cycle,
//   most significant slice first, and the compare stops at the first slice that
//   differs. Driven by a start/busy/done handshake beside the D-stage.
//
// Parameters
//   WIDTH    operand width
//   SLICE    bits compared per cycle (WIDTH must be a multiple of SLICE)
//
// Ports
//   clk      clock, rising edge
//   reset    synchronous, active-high
//   start_i  request, accepted in IDLE when flush_i is low
//   flush_i  abort an in-flight compare (also drops a same-cycle start)
//   op_i     0 BEQ 1 BNE 2 BLT 3 BGE 4 BLTU 5 BGEU 6 BLEZ 7 BGTZ
//   c1_i     operand A, sampled on accepted start
//   c2_i     operand B, sampled on accepted start, ignored for BLEZ/BGTZ
//   busy_o   high while a compare is running
//   done_o   one-cycle pulse when cmp_o is updated
//   cmp_o    branch-taken result, held until the next done
// -----------------------------------------------------------------------------
module branch_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] c1_i,
    input  logic [WIDTH-1:0] c2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cmp_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLT  = 3'd2;
    localparam logic [2:0] OP_BGE  = 3'd3;
    localparam logic [2:0] OP_BLTU = 3'd4;
    localparam logic [2:0] OP_BGEU = 3'd5;
    localparam logic [2:0] OP_BLEZ = 3'd6;
    localparam logic [2:0] OP_BGTZ = 3'd7;

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        op_q;
    logic [IDXW-1:0]   idx_q;
    logic              done_q, cmp_q;

    logic [WIDTH-1:0]  a_d, b_d;
    logic [SLICE-1:0]  sa, sb;
    logic              decided, lt, eq, res_d, is_signed, is_zero_op;
    int                base;

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so the slice engine only ever does unsigned compares.
    always_comb begin
        is_zero_op = (op_i == OP_BLEZ) || (op_i == OP_BGTZ);
        is_signed  = (op_i == OP_BLT) || (op_i == OP_BGE) || is_zero_op;
        a_d        = c1_i;
        b_d        = is_zero_op ? '0 : c2_i;
        if (is_signed) begin
            a_d[WIDTH-1] = ~a_d[WIDTH-1];
            b_d[WIDTH-1] = ~b_d[WIDTH-1];
        end
    end

    always_comb begin
        base    = int'(idx_q) * SLICE;
        sa      = a_q[base +: SLICE];
        sb      = b_q[base +: SLICE];
        // Equal slices only settle the result on the last (LSB) slice.
        decided = (sa != sb) || (idx_q == '0);
        lt      = (sa < sb);
        eq      = (sa == sb);
        case (op_q)
            OP_BEQ:           res_d = eq;
            OP_BNE:           res_d = !eq;
            OP_BLT, OP_BLTU:  res_d = lt;
            OP_BGE, OP_BGEU:  res_d = !lt;
            OP_BLEZ:          res_d = lt | eq;
            OP_BGTZ:          res_d = !(lt | eq);
            default:          res_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        op_q    <= op_i;
                        idx_q   <= IDX_TOP;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Flush beats a result decided in the same cycle.
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (decided) begin
                        cmp_q   <= res_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - IDXW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign cmp_o  = cmp_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
module tb_branch_cmp_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  st, fl, bsy, dn, cm;
    logic [2:0]  opv [3];
    logic [31:0] av  [3];
    logic [31:0] bv  [3];

    int          checks = 0;
    int          errors = 0;

    typedef struct { logic [2:0] op; logic [31:0] c1; logic [31:0] c2; bit cmp; int k; } vec_t;
    typedef struct { bit cmp; int k; } exp_t;

    vec_t tbl [12];
    exp_t sb_q [$];

    // Per-instance geometry: 32/8, 32/32, 16/4
    int W [3] = '{32, 32, 16};
    int S [3] = '{8, 32, 4};

    always #5 clk = ~clk;

    branch_cmp_seq #(.WIDTH(32), .SLICE(8)) u_d0 (
        .clk(clk), .reset(reset), .start_i(st[0]), .flush_i(fl[0]), .op_i(opv[0]),
        .c1_i(av[0]), .c2_i(bv[0]), .busy_o(bsy[0]), .done_o(dn[0]), .cmp_o(cm[0]));
    branch_cmp_seq #(.WIDTH(32), .SLICE(32)) u_d1 (
        .clk(clk), .reset(reset), .start_i(st[1]), .flush_i(fl[1]), .op_i(opv[1]),
        .c1_i(av[1]), .c2_i(bv[1]), .busy_o(bsy[1]), .done_o(dn[1]), .cmp_o(cm[1]));
    branch_cmp_seq #(.WIDTH(16), .SLICE(4)) u_d2 (
        .clk(clk), .reset(reset), .start_i(st[2]), .flush_i(fl[2]), .op_i(opv[2]),
        .c1_i(av[2][15:0]), .c2_i(bv[2][15:0]), .busy_o(bsy[2]), .done_o(dn[2]), .cmp_o(cm[2]));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: arithmetic compare on sign-extended values, latency from the
    // position of the first differing slice.
    function automatic exp_t model(input int w, input int s, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b_in);
        exp_t e;
        longint unsigned wm, sm, ua, ub;
        longint sa, sb;
        bit lt, eq, found, sgn;
        int ns;
        wm = (64'd1 << w) - 64'd1;
        sm = (64'd1 << s) - 64'd1;
        ua = {32'd0, a} & wm;
        ub = (op >= 3'd6) ? 64'd0 : ({32'd0, b_in} & wm);
        ns = w / s;
        e.k = ns;
        found = 1'b0;
        for (int i = ns - 1; i >= 0; i--)
            if (!found && (((ua >> (i * s)) & sm) != ((ub >> (i * s)) & sm))) begin
                found = 1'b1;
                e.k = ns - i;
            end
        sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
        sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
        sgn = (op == 3'd2) || (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
        lt = sgn ? (sa < sb) : (ua < ub);
        eq = (ua == ub);
        case (op)
            3'd0:       e.cmp = eq;
            3'd1:       e.cmp = !eq;
            3'd2, 3'd4: e.cmp = lt;
            3'd3, 3'd5: e.cmp = !lt;
            3'd6:       e.cmp = lt | eq;
            default:    e.cmp = !(lt | eq);
        endcase
        return e;
    endfunction

    // Drive a start for one cycle; the DUT must be busy after the accept edge.
    task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        st[d] = 1'b1; opv[d] = o; av[d] = a; bv[d] = b;
        @(posedge clk); #1;
        st[d] = 1'b0;
        chk($sformatf("busy_after_accept d%0d", d), bsy[d], 1);
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare result and latency.
    task automatic wait_done(input int d, input int cyc0, input string nm);
        int cyc = cyc0;
        exp_t e;
        while (!dn[d] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (sb_q.size() == 0) begin
            chk({nm, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            if (!dn[d]) begin
                checks++; errors++;
                $display("FAIL %s timeout: no done after %0d cycles, expected at %0d", nm, cyc, e.k);
            end else begin
                chk({nm, " cmp"}, cm[d], e.cmp);
                chk({nm, " latency"}, cyc, e.k);
            end
        end
    endtask

    task automatic idle_quiet(input int d, input int n, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (dn[d] || bsy[d]) seen = 1'b1;
        end
        chk({nm, " quiet"}, seen, 0);
    endtask

    initial begin
        exp_t e;
        logic [2:0] o;
        logic [31:0] a, b, m;

        tbl[0]  = '{3'd0, 32'h12345678, 32'h12345678, 1'b1, 4};
        tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1};
        tbl[2]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1};
        tbl[3]  = '{3'd7, 32'h00000000, 32'hDEADBEEF, 1'b0, 4};
        tbl[4]  = '{3'd6, 32'h80000000, 32'h12345678, 1'b1, 1};
        tbl[5]  = '{3'd5, 32'h00000100, 32'h000000FF, 1'b1, 3};
        tbl[6]  = '{3'd1, 32'h00000005, 32'h00000005, 1'b0, 4};
        tbl[7]  = '{3'd3, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1};
        tbl[8]  = '{3'd2, 32'h00010000, 32'h00020000, 1'b1, 2};
        tbl[9]  = '{3'd7, 32'h00000001, 32'hFFFFFFFF, 1'b1, 4};
        tbl[10] = '{3'd6, 32'h00000100, 32'h00000000, 1'b0, 3};
        tbl[11] = '{3'd5, 32'hFFFF0000, 32'hFFFF0001, 1'b0, 4};

        st = '0; fl = '0;
        for (int d = 0; d < 3; d++) begin opv[d] = '0; av[d] = '0; bv[d] = '0; end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", bsy[0], 0);
        chk("reset done", dn[0], 0);
        chk("reset cmp", cm[0], 0);
        reset = 1'b0;

        // Table-driven vectors on the 32/8 instance
        for (int i = 0; i < 12; i++) begin
            e.cmp = tbl[i].cmp; e.k = tbl[i].k;
            sb_q.push_back(e);
            issue(0, tbl[i].op, tbl[i].c1, tbl[i].c2);
            wait_done(0, 0, $sformatf("tbl%0d", i));
        end

        // Second start during RUN is ignored
        sb_q.push_back('{1'b1, 4});
        issue(0, 3'd1, 32'h11223344, 32'h11223345);
        st[0] = 1'b1; opv[0] = 3'd0; av[0] = 32'h1; bv[0] = 32'h2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_done(0, 2, "start_in_run");
        idle_quiet(0, 4, "start_in_run");

        // Flush at +2 of a 4-slice run: no done, cmp held (currently 1)
        issue(0, 3'd0, 32'h1, 32'h2);
        @(posedge clk); #1;
        fl[0] = 1'b1;
        @(posedge clk); #1;
        fl[0] = 1'b0;
        chk("flush busy", bsy[0], 0);
        chk("flush done", dn[0], 0);
        idle_quiet(0, 4, "flush");
        chk("flush cmp_held", cm[0], 1);

        // Flush in the same cycle a result (BEQ -> 0) would be decided
        issue(0, 3'd0, 32'h80000000, 32'h0);
        fl[0] = 1'b1;
        @(posedge clk); #1;
        fl[0] = 1'b0;
        chk("flush_vs_decide done", dn[0], 0);
        chk("flush_vs_decide busy", bsy[0], 0);
        chk("flush_vs_decide cmp", cm[0], 1);

        // Start together with flush in IDLE is dropped
        st[0] = 1'b1; fl[0] = 1'b1; opv[0] = 3'd0; av[0] = '0; bv[0] = '0;
        @(posedge clk); #1;
        st[0] = 1'b0; fl[0] = 1'b0;
        chk("start_flush busy", bsy[0], 0);
        idle_quiet(0, 5, "start_flush");

        // Reset mid-RUN clears everything, then a normal compare
        issue(0, 3'd0, 32'h12345678, 32'h12345678);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset busy", bsy[0], 0);
        chk("midreset done", dn[0], 0);
        chk("midreset cmp", cm[0], 0);
        sb_q.push_back('{1'b1, 4});
        issue(0, 3'd0, 32'h12345678, 32'h12345678);
        wait_done(0, 0, "after_reset");

        // Back-to-back: second start issued on the done cycle
        sb_q.push_back('{1'b1, 4});
        issue(0, 3'd0, 32'd5, 32'd5);
        wait_done(0, 0, "b2b_first");
        sb_q.push_back('{1'b0, 4});
        issue(0, 3'd1, 32'd5, 32'd5);
        wait_done(0, 0, "b2b_second");

        // Random ops/operands on each geometry against the model
        for (int d = 0; d < 3; d++) begin
            m = (W[d] == 32) ? 32'hFFFFFFFF : ((32'd1 << W[d]) - 32'd1);
            for (int i = 0; i < 40; i++) begin
                o = 3'($urandom_range(0, 7));
                a = $urandom & m;
                case ($urandom_range(0, 3))
                    0: b = a;
                    1: b = (a ^ (32'd1 << $urandom_range(0, W[d] - 1))) & m;
                    2: b = $urandom & m;
                    default: begin a = 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 3)); end
                endcase
                sb_q.push_back(model(W[d], S[d], o, a, b));
                issue(d, o, a, b);
                wait_done(d, 0, $sformatf("rnd d%0d i%0d op%0d", d, i, o));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
